// File: rtl/if_id_if.sv
// Fetch/hazard-to-decode bundle for the IF/ID stage; ifid_bubbles exists only
// when IFID_BUBBLE_COUNT_EN is defined.
interface if_id_if;
  // Handshake: a word transfers on a rising edge where if_valid && if_ready.
  // if_ready is a registered output; while if_valid && !if_ready the fetch
  // side must hold if_instr/if_pc4 stable.
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        if_ready;
  logic        stall;
  logic        flush;
  logic [31:0] ifid_out;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
`ifdef IFID_BUBBLE_COUNT_EN
  logic [15:0] ifid_bubbles;
`endif

  modport master (
    output if_instr, if_pc4, if_valid, stall, flush,
`ifdef IFID_BUBBLE_COUNT_EN
    input  ifid_bubbles,
`endif
    input  if_ready, ifid_out, ifid_pc4, ifid_valid
  );

  modport slave (
    input  if_instr, if_pc4, if_valid, stall, flush,
`ifdef IFID_BUBBLE_COUNT_EN
    output ifid_bubbles,
`endif
    output if_ready, ifid_out, ifid_pc4, ifid_valid
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a one-entry skid buffer and flush-to-NOP.
// Optional bubble counter enabled by defining IFID_BUBBLE_COUNT_EN.
module if_id_stage #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input logic    clk,
  input logic    rst,
  if_id_if.slave bus
);

  logic [31:0] out_q, out_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        skid_full_q, skid_full_d;
  logic        accept;
  logic        bubble;

  // if_ready is just the inverted skid flag, so it is a pure register output.
  assign accept = bus.if_valid && !skid_full_q;

  always_comb begin
    out_d        = out_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    skid_full_d  = skid_full_q;
    bubble       = 1'b0;
    if (bus.flush) begin
      out_d       = RESET_INSTR;
      valid_d     = 1'b0;
      skid_full_d = 1'b0;
    end else if (bus.stall) begin
      if (accept) begin
        skid_instr_d = bus.if_instr;
        skid_pc4_d   = bus.if_pc4;
        skid_full_d  = 1'b1;
      end
    end else if (skid_full_q) begin
      // Skid drains first so older words always reach decode before newer ones.
      out_d       = skid_instr_q;
      pc4_d       = skid_pc4_q;
      valid_d     = 1'b1;
      skid_full_d = 1'b0;
    end else if (accept) begin
      out_d   = bus.if_instr;
      pc4_d   = bus.if_pc4;
      valid_d = 1'b1;
    end else begin
      out_d   = RESET_INSTR;
      valid_d = 1'b0;
      bubble  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= RESET_INSTR;
      pc4_q        <= 32'h0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc4_q   <= 32'h0;
      skid_full_q  <= 1'b0;
    end else begin
      out_q        <= out_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_full_q  <= skid_full_d;
    end
  end

  assign bus.ifid_out   = out_q;
  assign bus.ifid_pc4   = pc4_q;
  assign bus.ifid_valid = valid_q;
  assign bus.if_ready   = !skid_full_q;

`ifdef IFID_BUBBLE_COUNT_EN
  logic [15:0] bubbles_q, bubbles_d;

  always_comb begin
    bubbles_d = bubbles_q;
    if (bubble && bubbles_q != 16'hFFFF) bubbles_d = bubbles_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) bubbles_q <= 16'h0;
    else     bubbles_q <= bubbles_d;
  end

  assign bus.ifid_bubbles = bubbles_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif

endmodule
